// File: rtl/instr_encode_loader.sv
// instr_encode_loader: takes instruction descriptors from a valid/ready stream,
// encodes each into a 32-bit MIPS R/I/J word and writes the words sequentially
// into instruction memory. The CPU is held in reset until a full program is in.
module instr_encode_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LP_BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_TOP      = '1;  // word address DEPTH-1
  localparam logic [ADDR_W-1:0] LP_ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LP_CNT_ONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_next_addr;
  // Set when the final word is being written; done/cpu_hold follow one cycle later.
  logic              r_fin;

  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_accept;

  assign w_accept = in_valid & r_in_ready;

  // Encode the current descriptor into a MIPS word and flag illegal kinds.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_word  = '0;
    w_legal = 1'b1;
    case (in_kind)
      4'd0:    w_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h20};  // ADD
      4'd1:    w_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h22};  // SUB
      4'd2:    w_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h24};  // AND
      4'd3:    w_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h25};  // OR
      4'd4:    w_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h2A};  // SLT
      4'd5:    w_word = {6'h23, in_rs, in_rt, in_imm};              // LW
      4'd6:    w_word = {6'h2B, in_rs, in_rt, in_imm};              // SW
      4'd7:    w_word = {6'h04, in_rs, in_rt, in_imm};              // BEQ
      4'd8:    w_word = {6'h08, in_rs, in_rt, in_imm};              // ADDI
      4'd9:    w_word = {6'h02, in_target};                         // J
      default: w_legal = 1'b0;
    endcase
  end

  // Load-control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= LP_BASE;
      r_imem_wdata <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_count      <= '0;
      r_next_addr  <= LP_BASE;
      r_fin        <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          // start is deliberately ignored here so a running load is never restarted.
          if (w_accept) begin
            if (!w_legal) begin
              r_state    <= ST_ERR;
              r_error    <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_next_addr;
              r_imem_wdata <= w_word;
              r_count      <= r_count + LP_CNT_ONE;
              if (in_last) begin
                r_state    <= ST_DONE;
                r_in_ready <= 1'b0;
                r_fin      <= 1'b1;
              end else if (r_next_addr == LP_TOP) begin
                // Memory full and program not finished: abort rather than wrap to 0.
                r_state    <= ST_ERR;
                r_error    <= 1'b1;
                r_in_ready <= 1'b0;
              end else begin
                r_next_addr <= r_next_addr + LP_ADDR_ONE;
              end
            end
          end
        end
        default: begin
          if (start) begin
            r_state     <= ST_LOAD;
            r_in_ready  <= 1'b1;
            r_next_addr <= LP_BASE;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_fin       <= 1'b0;
          end else if (r_fin) begin
            // The last word was written in the previous cycle; release the CPU now.
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_fin      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign error      = r_error;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed testbench for instr_encode_loader: a default-size instance plus a
// 4-word instance (ADDR_W=2) sharing the same stimulus for the overflow case.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, imem_we, cpu_hold, done, error;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;

  logic        s_in_ready, s_imem_we, s_cpu_hold, s_done, s_error;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(6), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error), .count(count)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_hold(s_cpu_hold), .done(s_done), .error(s_error),
    .count(s_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg,
                       input logic last);
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tg;
    in_last   = last;
    in_valid  = 1'b1;
  endtask

  // Present one descriptor for one cycle and check the resulting write.
  task automatic send(input string tag, input logic [3:0] k, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tg, input logic last,
                      input logic [5:0] exp_addr, input logic [31:0] exp_word);
    drive(k, rs, rt, rd, imm, tg, last);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    tick();
    check({tag, ".we"}, 32'(imem_we), 32'd1);
    check({tag, ".addr"}, 32'(imem_addr), 32'(exp_addr));
    check({tag, ".wdata"}, imem_wdata, exp_word);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    tick();
    tick();
    check("rst.ready", 32'(in_ready), 32'd0);
    check("rst.we", 32'(imem_we), 32'd0);
    check("rst.addr", 32'(imem_addr), 32'd0);
    check("rst.wdata", imem_wdata, 32'd0);
    check("rst.hold", 32'(cpu_hold), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.error", 32'(error), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    reset = 1'b0;
    tick();
    check("idle.ready", 32'(in_ready), 32'd0);

    // 1) single ADD as the whole program
    do_start();
    send("t1.add", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 6'd0, 32'h0022_1820);
    in_valid = 1'b0;
    check("t1.count", 32'(count), 32'd1);
    check("t1.done_early", 32'(done), 32'd0);
    check("t1.hold_early", 32'(cpu_hold), 32'd1);
    check("t1.ready_after_last", 32'(in_ready), 32'd0);
    tick();
    check("t1.we_off", 32'(imem_we), 32'd0);
    check("t1.done", 32'(done), 32'd1);
    check("t1.hold", 32'(cpu_hold), 32'd0);

    // 2) back-to-back I/J-type descriptors
    do_start();
    check("t2.reload_done", 32'(done), 32'd0);
    check("t2.reload_hold", 32'(cpu_hold), 32'd1);
    check("t2.reload_count", 32'(count), 32'd0);
    send("t2.lw",  4'd5, 5'd0, 5'd2, 5'd0, 16'h0004, 26'h0, 1'b0, 6'd0, 32'h8C02_0004);
    send("t2.sw",  4'd6, 5'd4, 5'd5, 5'd0, 16'h0008, 26'h0, 1'b0, 6'd1, 32'hAC85_0008);
    send("t2.beq", 4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 6'd2, 32'h1022_FFFF);
    send("t2.j",   4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 6'd3, 32'h0800_0010);
    in_valid = 1'b0;
    check("t2.count", 32'(count), 32'd4);
    tick();
    check("t2.done", 32'(done), 32'd1);
    check("t2.we_off", 32'(imem_we), 32'd0);

    // 3) illegal kind mid-stream; also covers SUB/AND/OR/SLT/ADDI encodings
    do_start();
    send("t3.sub",  4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 6'd0, 32'h0022_1822);
    send("t3.and",  4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 6'd1, 32'h0085_3024);
    send("t3.or",   4'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b0, 6'd2, 32'h00E8_4825);
    send("t3.slt",  4'd4, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 1'b0, 6'd3, 32'h014B_602A);
    send("t3.addi", 4'd8, 5'd3, 5'd4, 5'd0, 16'h1234, 26'h0, 1'b0, 6'd4, 32'h2064_1234);
    drive(4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t3.we", 32'(imem_we), 32'd0);
    check("t3.error", 32'(error), 32'd1);
    check("t3.ready", 32'(in_ready), 32'd0);
    check("t3.hold", 32'(cpu_hold), 32'd1);
    check("t3.count", 32'(count), 32'd5);
    tick();
    check("t3.error_hold", 32'(error), 32'd1);
    check("t3.done", 32'(done), 32'd0);

    // 6) start pulse during LOAD is ignored
    do_start();
    check("t6.error_clr", 32'(error), 32'd0);
    send("t6.w0", 4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 6'd0, 32'h0021_0820);
    start = 1'b1;
    send("t6.w1", 4'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0, 6'd1, 32'h0042_1020);
    start = 1'b0;
    send("t6.w2", 4'd0, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0, 1'b1, 6'd2, 32'h0063_1820);
    in_valid = 1'b0;
    check("t6.count", 32'(count), 32'd3);

    // 5) in_valid gaps, then reset in the middle of a load
    tick();
    do_start();
    send("t5.w0", 4'd5, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0, 1'b0, 6'd0, 32'h8C22_0010);
    in_valid = 1'b0;
    tick();
    check("t5.gap_we", 32'(imem_we), 32'd0);
    check("t5.gap_count", 32'(count), 32'd1);
    send("t5.w1", 4'd5, 5'd1, 5'd3, 5'd0, 16'h0014, 26'h0, 1'b0, 6'd1, 32'h8C23_0014);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("t5.rst_we", 32'(imem_we), 32'd0);
    check("t5.rst_ready", 32'(in_ready), 32'd0);
    check("t5.rst_addr", 32'(imem_addr), 32'd0);
    check("t5.rst_count", 32'(count), 32'd0);
    check("t5.rst_hold", 32'(cpu_hold), 32'd1);
    tick();
    do_start();
    send("t5.reload", 4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1, 6'd0, 32'h0BFF_FFFF);
    in_valid = 1'b0;
    check("t5.reload_count", 32'(count), 32'd1);
    tick();

    // 4) overflow on the 4-word instance: 5 descriptors, none last
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive(4'd8, 5'(i), 5'(i), 5'd0, 16'(i), 26'h0, 1'b0);
      check($sformatf("t4.ready%0d", i), 32'(s_in_ready), 32'd1);
      tick();
      check($sformatf("t4.we%0d", i), 32'(s_imem_we), 32'd1);
      check($sformatf("t4.addr%0d", i), 32'(s_imem_addr), 32'(i));
      check($sformatf("t4.wdata%0d", i), s_imem_wdata, {6'h08, 5'(i), 5'(i), 16'(i)});
    end
    check("t4.error", 32'(s_error), 32'd1);
    check("t4.ready_off", 32'(s_in_ready), 32'd0);
    check("t4.count", 32'(s_count), 32'd4);
    drive(4'd8, 5'd4, 5'd4, 5'd0, 16'd4, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t4.fifth_we", 32'(s_imem_we), 32'd0);
    check("t4.fifth_addr", 32'(s_imem_addr), 32'd3);
    check("t4.fifth_count", 32'(s_count), 32'd4);
    check("t4.hold", 32'(s_cpu_hold), 32'd1);
    check("t4.done", 32'(s_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
